// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the front end of the core:
//            opcode encodings used by decode, the canonical NOP, the fetch
//            state enum and the {instr, pc} entry carried from fetch to decode.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

    // Major opcode field (instr[6:0]) encodings consumed by decode.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small synchronous FIFO of fetch entries between the instruction
//            memory response path and decode. Flush wins over push and pop.
// Ports    : clk, rst_n        clock, asynchronous active-low reset
//            push_i/push_data_i write one entry
//            pop_i             retire the head entry
//            flush_i           empty the FIFO
//            count_o           number of valid entries
//            empty_o/full_o    status flags
//            head_o            oldest entry (valid when !empty_o)
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output fetch_entry_t               head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;

    logic           w_do_push;
    logic           w_do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when a pop frees a slot in
    // the same cycle; a pop from an empty FIFO is ignored.
    assign w_do_push = push_i & (~full_o | pop_i);
    assign w_do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Owns the fetch PC, issues in-order
//            requests to instruction memory, buffers returned words with
//            their PCs and hands them to decode. Redirects flush the buffer
//            and discard responses to requests already in flight.
// Ports    : clk, rst_n                    clock, asynchronous active-low reset
//            fetch_en                      permits issue of new requests
//            imem_req_valid/ready/addr     request channel (valid/ready)
//            imem_rsp_valid/data           response channel (valid only)
//            redirect_valid/redirect_pc    one-cycle fetch redirect
//            id_valid/id_ready             decode handshake
//            id_instr/id_pc                instruction and its address
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t   state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    ret_pc_q, ret_pc_d;
    logic [CW-1:0]  outstanding_q, outstanding_d;
    logic [CW-1:0]  drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]  w_fifo_count;
    logic           w_fifo_empty;
    logic           w_fifo_full;
    fetch_entry_t   w_fifo_head;
    fetch_entry_t   w_push_entry;

    logic           w_run;
    logic [CW:0]    w_occupancy;
    logic           w_credit;
    logic           w_req_fire;
    logic           w_dropping;
    logic           w_push;
    logic           w_pop;
    logic           w_flush;
    logic [31:0]    w_target;

    assign w_run    = (state_q == RUN);
    assign w_target = align_word(redirect_pc);

    // Every accepted request, stale or not, holds a slot until it returns,
    // so the FIFO can never be asked to take more than it holds.
    assign w_occupancy = {1'b0, outstanding_q} + {1'b0, w_fifo_count};
    assign w_credit    = (w_occupancy < (CW + 1)'(DEPTH));

    assign imem_req_valid = w_run & fetch_en & w_credit & ~redirect_valid;
    assign imem_req_addr  = pc_q;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign w_dropping   = (drop_cnt_q != '0);
    assign w_flush      = w_run & redirect_valid;
    // A response landing in the redirect cycle belongs to the old stream.
    assign w_push       = w_run & imem_rsp_valid & ~w_dropping & ~redirect_valid & ~w_fifo_full;
    assign w_push_entry = '{instr: imem_rsp_data, pc: ret_pc_q};

    assign id_valid = ~w_fifo_empty & ~redirect_valid;
    assign w_pop    = id_valid & id_ready;
    assign id_instr = w_fifo_head.instr;
    assign id_pc    = w_fifo_head.pc;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ret_pc_d      = ret_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (redirect_valid) begin
                    pc_d = w_target;
                end
            end

            RUN: begin
                if (w_req_fire && !imem_rsp_valid) begin
                    outstanding_d = outstanding_q + 1'b1;
                end else if (!w_req_fire && imem_rsp_valid && outstanding_q != '0) begin
                    outstanding_d = outstanding_q - 1'b1;
                end

                if (redirect_valid) begin
                    pc_d     = w_target;
                    ret_pc_d = w_target;
                    // Everything still in flight is stale; a response
                    // arriving right now is discarded directly.
                    if (imem_rsp_valid && outstanding_q != '0) begin
                        drop_cnt_d = outstanding_q - 1'b1;
                    end else begin
                        drop_cnt_d = outstanding_q;
                    end
                end else begin
                    if (w_req_fire) begin
                        pc_d = pc_q + 32'd4;
                    end
                    if (imem_rsp_valid && w_dropping) begin
                        drop_cnt_d = drop_cnt_q - 1'b1;
                    end
                    if (w_push) begin
                        ret_pc_d = ret_pc_q + 32'd4;
                    end
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            ret_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ret_pc_q      <= ret_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (w_flush),
        .count_o     (w_fifo_count),
        .empty_o     (w_fifo_empty),
        .full_o      (w_fifo_full),
        .head_o      (w_fifo_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A queue-based reference
//            (memory queue, buffer queue, drop counter) predicts outputs on
//            every falling edge; directed scenarios add literal expectations.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b1;
    logic        fetch_en       = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        id_ready       = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string name, input logic [31:0] q[$], input int idx,
                         input logic [31:0] exp);
        logic [31:0] v;
        v = (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
        chk(name, v, exp);
    endtask

    // Memory contents: a fixed hash of the address (address 0 holds a NOP).
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ NOP_INSTR;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t        mem_q[$];      // accepted requests awaiting a response
    fetch_entry_t m_fifo[$];     // entries decode can see
    logic         m_run   = 1'b0;
    logic [31:0]  m_pc    = RESET_PC;
    logic [31:0]  m_ret   = RESET_PC;
    int           m_drop  = 0;
    int           cyc     = 0;
    int           lat     = 1;
    logic [31:0]  pop_log[$];
    logic [31:0]  req_log[$];
    bit           will_rsp_next = 1'b0;
    int           fifo_next     = 0;

    logic         e_rv, e_iv, rsp;
    logic [31:0]  rdata;
    int           out_now;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
            if (id_valid && id_ready)             pop_log.push_back(id_pc);
        end
        if (!rst_n) begin
            chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            chk("rst_id_valid",  {31'b0, id_valid},       32'd0);
            chk("rst_id_instr",  id_instr,                32'd0);
            chk("rst_id_pc",     id_pc,                   32'd0);
            mem_q.delete();
            m_fifo.delete();
            m_run  = 1'b0;
            m_pc   = RESET_PC;
            m_ret  = RESET_PC;
            m_drop = 0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            will_rsp_next  = 1'b0;
            fifo_next      = 0;
        end else begin
            out_now = mem_q.size();
            e_rv = m_run && fetch_en && (out_now + m_fifo.size() < DEPTH) && !redirect_valid;
            e_iv = (m_fifo.size() > 0) && !redirect_valid;
            chk("req_valid", {31'b0, imem_req_valid}, {31'b0, e_rv});
            if (e_rv) chk("req_addr", imem_req_addr, m_pc);
            chk("id_valid", {31'b0, id_valid}, {31'b0, e_iv});
            if (e_iv) begin
                chk("id_pc",    id_pc,    m_fifo[0].pc);
                chk("id_instr", id_instr, m_fifo[0].instr);
            end

            // memory: in-order, one response per cycle once due
            rsp   = 1'b0;
            rdata = 32'h0;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                rsp   = 1'b1;
                rdata = memfn(mem_q[0].addr);
                void'(mem_q.pop_front());
            end
            imem_rsp_valid = rsp;
            imem_rsp_data  = rdata;

            // state after the coming rising edge
            if (!m_run) begin
                if (redirect_valid) m_pc = redirect_pc & 32'hFFFF_FFFC;
                m_run = 1'b1;
            end else if (redirect_valid) begin
                m_pc   = redirect_pc & 32'hFFFF_FFFC;
                m_ret  = m_pc;
                m_fifo.delete();
                m_drop = out_now - (rsp ? 1 : 0);
            end else begin
                if (e_rv && imem_req_ready) begin
                    mem_q.push_back('{addr: m_pc, due: cyc + lat});
                    m_pc = m_pc + 32'd4;
                end
                if (e_iv && id_ready) void'(m_fifo.pop_front());
                if (rsp) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        m_fifo.push_back('{instr: rdata, pc: m_ret});
                        m_ret = m_ret + 32'd4;
                    end
                end
            end
            will_rsp_next = (mem_q.size() > 0) && (mem_q[0].due <= cyc + 1);
            fifo_next     = m_fifo.size();
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset(input logic rdy_id);
        @(posedge clk); #1;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        fetch_en       = 1'b1;
        imem_req_ready = 1'b1;
        id_ready       = rdy_id;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pop_log.delete();
        req_log.delete();
    endtask

    task automatic quiesce();
        @(posedge clk); #1;
        fetch_en = 1'b0;
        id_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        pop_log.delete();
        req_log.delete();
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        bit found;
        #2 rst_n = 1'b0;

        // 1: reset release, always-ready memory, 1-cycle latency
        lat = 1;
        do_reset(1'b1);
        @(negedge clk); #1;
        chk("boot_no_req", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clk); #1;
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr",  imem_req_addr, 32'h0);
        repeat (12) @(posedge clk);
        #1;
        chk_q("s1_pop0", pop_log, 0, 32'h0);
        chk_q("s1_pop1", pop_log, 1, 32'h4);
        chk_q("s1_pop2", pop_log, 2, 32'h8);

        // 2: decode stalled for 10 cycles
        do_reset(1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("stall_id_valid",  {31'b0, id_valid},       32'd1);
        chk("stall_head_instr", id_instr, 32'h0000_0013);
        @(posedge clk); #1;
        pop_log.delete();
        id_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_q("s2_pop0", pop_log, 0, 32'h0);
        chk_q("s2_pop1", pop_log, 1, 32'h4);
        chk_q("s2_pop2", pop_log, 2, 32'h8);
        chk_q("s2_pop3", pop_log, 3, 32'hC);

        // 3: redirect with 0x8 and 0xC in flight, 3-cycle latency
        lat = 3;
        do_reset(1'b1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk); #1;
            if (imem_req_valid && imem_req_ready && imem_req_addr == 32'hC) found = 1'b1;
        end
        chk("s3_found_0xC", {31'b0, found}, 32'd1);
        @(posedge clk); #1;
        pulse_redirect(32'h100);
        repeat (20) @(posedge clk);
        #1;
        chk_q("s3_pop0", pop_log, 0, 32'h100);
        chk_q("s3_pop1", pop_log, 1, 32'h104);

        // 4: misaligned redirect target, then throttled ready
        lat = 1;
        quiesce();
        pulse_redirect(32'h203);
        @(negedge clk); #1;
        chk("s4_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("s4_req_addr",  imem_req_addr, 32'h200);
        repeat (10) @(posedge clk);
        #1;
        chk_q("s4_pop0", pop_log, 0, 32'h200);
        lat = 2;
        for (int i = 0; i < 24; i++) begin
            imem_req_ready = (i % 3) != 0;
            id_ready       = (i % 4) != 1;
            @(posedge clk); #1;
        end
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;

        // 5: redirect coinciding with a response and a pop
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #1;
            if (will_rsp_next && fifo_next > 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h300;
                found          = 1'b1;
            end
        end
        chk("s5_found", {31'b0, found}, 32'd1);
        @(negedge clk); #1;
        chk("s5_rsp_in_redirect", {31'b0, imem_rsp_valid}, 32'd1);
        chk("s5_id_valid_redirect", {31'b0, id_valid}, 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk); #1;
        chk("s5_id_valid_after", {31'b0, id_valid}, 32'd0);

        // 6: address wrap-around, then reset mid-stream
        quiesce();
        pulse_redirect(32'hFFFF_FFFC);
        repeat (15) @(posedge clk);
        #1;
        chk_q("s6_req0", req_log, 0, 32'hFFFF_FFFC);
        chk_q("s6_req1", req_log, 1, 32'h0000_0000);
        chk_q("s6_pop0", pop_log, 0, 32'hFFFF_FFFC);
        chk_q("s6_pop1", pop_log, 1, 32'h0000_0000);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_id_valid",  {31'b0, id_valid},       32'd0);
        chk("s6_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
